// File: rtl/spi_slave_frame.sv
`timescale 1ns/1ps
// Oversampled SPI slave: receives one framed NPU command, then returns a response word.
// Optional macro SPI_PARITY_EN appends an odd-parity bit to every received frame.
module spi_slave_frame #(
   parameter int CMD_W       = 8,
   parameter int TILE_W      = 3,
   parameter int OP_W        = 3,
   parameter int DATA_W      = 8,
   parameter int RESP_W      = 8,
   parameter int SPI_MODE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso,
   output logic              miso_oe,
   output logic [CMD_W-1:0]  cmd,
   output logic [TILE_W-1:0] tile_i,
   output logic [TILE_W-1:0] tile_j,
   output logic [OP_W-1:0]   op_code,
   output logic [DATA_W-1:0] data_in,
   output logic              rx_valid,
   input  logic [RESP_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              frame_err,
   output logic              tx_underrun,
   output logic              parity_err
);

   localparam int FRAME_W = CMD_W + 2*TILE_W + OP_W + DATA_W;
`ifdef SPI_PARITY_EN
   localparam int RX_BITS = FRAME_W + 1;
`else
   localparam int RX_BITS = FRAME_W;
`endif
   localparam int MAX_BITS = (RX_BITS > RESP_W) ? RX_BITS : RESP_W;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BITS - 1);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(RESP_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam bit CPOL = (SPI_MODE & 2) != 0;
   localparam bit CPHA = (SPI_MODE & 1) != 0;

   typedef enum logic [1:0] {S_IDLE, S_RX, S_TX, S_DONE} state_t;
   state_t r_state, w_next;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
   logic                   r_sclk_d, r_cs_d;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [RX_BITS-2:0]     r_frame;
   logic [RESP_W-1:0]      r_tx_sr;
   logic                   r_miso, r_loaded, r_started;
   logic                   r_rx_valid, r_frame_err, r_tx_underrun;
   logic [CMD_W-1:0]       r_cmd;
   logic [TILE_W-1:0]      r_tile_i, r_tile_j;
   logic [OP_W-1:0]        r_op;
   logic [DATA_W-1:0]      r_data;

   logic w_sclk_s, w_mosi_s, w_cs_s, w_rise, w_fall, w_lead, w_trail;
   logic w_sample, w_shift, w_cs_fall, w_cs_rise, w_abort, w_rx_done, w_tx_done;
   logic w_load, w_par_ok;
   logic [RX_BITS-1:0] w_frame_next;
   logic [FRAME_W-1:0] w_fields;
   logic [RESP_W-1:0]  w_tx_src;

   // Pin synchronisers plus one history flop for edge detection; idle levels avoid a false edge out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= {SYNC_STAGES{CPOL}};
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sclk_d    <= CPOL;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
   assign w_rise    = w_sclk_s & ~r_sclk_d;
   assign w_fall    = ~w_sclk_s & r_sclk_d;
   assign w_lead    = CPOL ? w_fall : w_rise;
   assign w_trail   = CPOL ? w_rise : w_fall;
   assign w_sample  = CPHA ? w_trail : w_lead;
   assign w_shift   = CPHA ? w_lead : w_trail;
   assign w_cs_fall = ~w_cs_s & r_cs_d;
   assign w_cs_rise = w_cs_s & ~r_cs_d;
   assign w_abort   = ((r_state == S_RX) || (r_state == S_TX)) && w_cs_rise;
   assign w_rx_done = (r_state == S_RX) && w_sample && (r_bit_cnt == RX_LAST) && !w_cs_rise;
   assign w_tx_done = (r_state == S_TX) && w_sample && (r_bit_cnt == TX_LAST) && !w_cs_rise;

   assign w_frame_next = {r_frame, w_mosi_s};
   assign w_fields     = w_frame_next[RX_BITS-1 -: FRAME_W];
`ifdef SPI_PARITY_EN
   assign w_par_ok = ^w_frame_next;
`else
   assign w_par_ok = 1'b1;
`endif
   assign w_load   = tx_valid & tx_ready;
   assign w_tx_src = w_load ? tx_data : r_tx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_cs_fall) w_next = S_RX;
         S_RX:   if (w_abort) w_next = S_IDLE; else if (w_rx_done) w_next = S_TX;
         S_TX:   if (w_abort) w_next = S_IDLE; else if (w_tx_done) w_next = S_DONE;
         S_DONE: if (w_cs_s) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx_ready = 1'b0;
      miso     = 1'b0;
      miso_oe  = ~w_cs_s;
      if (r_state == S_TX) begin
         tx_ready = ~r_loaded & ~r_started;
         miso     = r_miso;
      end
   end

   // Datapath: receive shift, field latch, response load/shift and event pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0; r_frame <= '0; r_tx_sr <= '0;
         r_miso <= 1'b0; r_loaded <= 1'b0; r_started <= 1'b0;
         r_rx_valid <= 1'b0; r_frame_err <= 1'b0; r_tx_underrun <= 1'b0;
         r_cmd <= '0; r_tile_i <= '0; r_tile_j <= '0; r_op <= '0; r_data <= '0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_frame_err   <= w_abort;
         unique case (r_state)
            S_RX: begin
               if (w_sample) begin
                  r_frame   <= w_frame_next[RX_BITS-2:0];
                  r_bit_cnt <= (r_bit_cnt == RX_LAST) ? '0 : r_bit_cnt + CNT_ONE;
               end
               if (w_rx_done && w_par_ok) begin
                  r_cmd      <= w_fields[FRAME_W-1 -: CMD_W];
                  r_tile_i   <= w_fields[FRAME_W-CMD_W-1 -: TILE_W];
                  r_tile_j   <= w_fields[DATA_W+OP_W+TILE_W-1 -: TILE_W];
                  r_op       <= w_fields[DATA_W+OP_W-1 -: OP_W];
                  r_data     <= w_fields[DATA_W-1:0];
                  r_rx_valid <= 1'b1;
               end
            end
            S_TX: begin
               if (w_load) begin
                  r_tx_sr  <= tx_data;
                  r_loaded <= 1'b1;
               end
               // A load in the same clk as the first shift edge still supplies the first bit
               if (w_shift && !r_started) begin
                  r_started     <= 1'b1;
                  r_miso        <= w_tx_src[RESP_W-1];
                  r_tx_sr       <= w_tx_src << 1;
                  r_tx_underrun <= ~w_load & ~r_loaded;
               end else if (w_shift) begin
                  r_miso  <= r_tx_sr[RESP_W-1];
                  r_tx_sr <= r_tx_sr << 1;
               end
               if (w_sample) r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
            default: begin
               r_bit_cnt <= '0; r_tx_sr <= '0; r_miso <= 1'b0;
               r_loaded  <= 1'b0; r_started <= 1'b0;
            end
         endcase
      end
   end

`ifdef SPI_PARITY_EN
   logic r_parity_err;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_parity_err <= 1'b0;
      else     r_parity_err <= w_rx_done & ~w_par_ok;
   end
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign cmd         = r_cmd;
   assign tile_i      = r_tile_i;
   assign tile_j      = r_tile_j;
   assign op_code     = r_op;
   assign data_in     = r_data;
   assign rx_valid    = r_rx_valid;
   assign frame_err   = r_frame_err;
   assign tx_underrun = r_tx_underrun;

endmodule
